// File: rtl/lfsr_digital_modulator.sv
// Pseudo-random bit source (x^5+x^3+1 LFSR) at a programmable bit rate, driving
// registered ASK/FSK/BPSK/QPSK versions of the DDS carriers for the signal selector.
module lfsr_digital_modulator #(
  parameter int          BIT_PERIOD = 50_000_000,
  parameter logic [4:0]  LFSR_SEED  = 5'b00001,
  parameter logic [11:0] MIDSCALE   = 12'd2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] sin_wave,
  input  logic [11:0] cos_wave,
  input  logic [11:0] sin_wave_f2,
  output logic [4:0]  lfsr,
  output logic        bit_tick,
  output logic [11:0] ask_mod,
  output logic [11:0] fsk_mod,
  output logic [11:0] bpsk_mod,
  output logic [11:0] sin_qpsk
);

  localparam int             CW       = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BIT_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    lfsr_q, lfsr_d;
  logic          tick_q, tick_d;
  logic [1:0]    sym_q, sym_d;
  logic          phase_q, phase_d;
  logic [11:0]   ask_q, ask_d;
  logic [11:0]   fsk_q, fsk_d;
  logic [11:0]   bpsk_q, bpsk_d;
  logic [11:0]   qpsk_q, qpsk_d;
  logic          wrap;
  logic          data_bit;

  // bit_tick is a strobe with no back-pressure: high for exactly the one cycle in
  // which lfsr shows its freshly advanced value; the consumer must sample it then.
  always_comb begin
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    tick_d   = 1'b0;
    sym_d    = sym_q;
    phase_d  = phase_q;
    wrap     = enable && (cnt_q == CNT_LAST);
    data_bit = lfsr_q[0];

    if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    if (wrap) begin
      tick_d  = 1'b1;
      // An all-zero register would never leave zero, so reload the seed instead.
      lfsr_d  = (lfsr_q == 5'd0) ? LFSR_SEED : {lfsr_q[0] ^ lfsr_q[2], lfsr_q[4:1]};
      phase_d = ~phase_q;
      if (phase_q) begin
        sym_d = lfsr_q[1:0];
      end
    end

    ask_d  = data_bit ? sin_wave : MIDSCALE;
    fsk_d  = data_bit ? sin_wave_f2 : sin_wave;
    bpsk_d = data_bit ? sin_wave : ~sin_wave;

    // Complement of offset-binary is 4095 - x, i.e. a 180 degree phase flip.
    unique case (sym_q)
      2'b00:   qpsk_d = sin_wave;
      2'b01:   qpsk_d = cos_wave;
      2'b11:   qpsk_d = ~sin_wave;
      default: qpsk_d = ~cos_wave;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      tick_q  <= 1'b0;
      sym_q   <= 2'b00;
      phase_q <= 1'b0;
      ask_q   <= MIDSCALE;
      fsk_q   <= MIDSCALE;
      bpsk_q  <= MIDSCALE;
      qpsk_q  <= MIDSCALE;
    end else begin
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      tick_q  <= tick_d;
      sym_q   <= sym_d;
      phase_q <= phase_d;
      ask_q   <= ask_d;
      fsk_q   <= fsk_d;
      bpsk_q  <= bpsk_d;
      qpsk_q  <= qpsk_d;
    end
  end

  assign lfsr     = lfsr_q;
  assign bit_tick = tick_q;
  assign ask_mod  = ask_q;
  assign fsk_mod  = fsk_q;
  assign bpsk_mod = bpsk_q;
  assign sin_qpsk = qpsk_q;

endmodule

// File: tb/tb_lfsr_digital_modulator.sv
// Bench for lfsr_digital_modulator with BIT_PERIOD=4: tick-driven LFSR scoreboard
// plus directed waveform checks using fixed carriers 3000 / 1000 / 500.
module tb_lfsr_digital_modulator;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [11:0] sin_wave;
  logic [11:0] cos_wave;
  logic [11:0] sin_wave_f2;
  logic [4:0]  lfsr;
  logic        bit_tick;
  logic [11:0] ask_mod;
  logic [11:0] fsk_mod;
  logic [11:0] bpsk_mod;
  logic [11:0] sin_qpsk;

  int          total;
  int          bad;
  int          gap;
  logic [4:0]  exp_q[$];
  logic [4:0]  seq[31];

  lfsr_digital_modulator #(
    .BIT_PERIOD (4),
    .LFSR_SEED  (5'b00001),
    .MIDSCALE   (12'd2048)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sin_wave    (sin_wave),
    .cos_wave    (cos_wave),
    .sin_wave_f2 (sin_wave_f2),
    .lfsr        (lfsr),
    .bit_tick    (bit_tick),
    .ask_mod     (ask_mod),
    .fsk_mod     (fsk_mod),
    .bpsk_mod    (bpsk_mod),
    .sin_qpsk    (sin_qpsk)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // hand-computed responses for sin=3000, cos=1000, f2=500
  function automatic logic [11:0] ask_exp(input logic d);
    return d ? 12'd3000 : 12'd2048;
  endfunction
  function automatic logic [11:0] fsk_exp(input logic d);
    return d ? 12'd500 : 12'd3000;
  endfunction
  function automatic logic [11:0] bpsk_exp(input logic d);
    return d ? 12'd3000 : 12'd1095;
  endfunction
  function automatic logic [11:0] qpsk_exp(input logic [1:0] s);
    case (s)
      2'b00:   return 12'd3000;
      2'b01:   return 12'd1000;
      2'b11:   return 12'd1095;
      default: return 12'd3095;
    endcase
  endfunction

  // scoreboard monitor: pops the expected LFSR state on every bit_tick
  task automatic monitor();
    int         en_cnt;
    logic       prev_tick;
    logic [4:0] e;
    en_cnt    = 0;
    prev_tick = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) en_cnt = 0;
      else if (enable) en_cnt++;
      @(negedge clk);
      if (bit_tick) begin
        gap    = en_cnt;
        en_cnt = 0;
        check("tick_width", 12'(prev_tick), 12'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tick: got tick with lfsr=%b, expected no tick", lfsr);
        end else begin
          e = exp_q.pop_front();
          check("sb_lfsr", 12'(lfsr), 12'(e));
        end
      end
      prev_tick = bit_tick;
    end
  endtask

  // driver helpers
  task automatic wait_tick(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bit_tick && cyc < 64);
    check({name, "_timeout"}, 12'(bit_tick), 12'd1);
  endtask

  task automatic check_wave(input string tag, input logic d, input logic [1:0] s);
    check({tag, "_ask"},  ask_mod,  ask_exp(d));
    check({tag, "_fsk"},  fsk_mod,  fsk_exp(d));
    check({tag, "_bpsk"}, bpsk_mod, bpsk_exp(d));
    check({tag, "_qpsk"}, sin_qpsk, qpsk_exp(s));
  endtask

  initial begin
    int         cyc;
    logic       prev_d;
    logic       new_d;
    logic [1:0] sym;
    logic [1:0] prev_sym;
    logic [4:0] t;

    seq = '{5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b10010, 5'b01001, 5'b10100,
            5'b11010, 5'b01101, 5'b00110, 5'b10011, 5'b11001, 5'b11100, 5'b11110,
            5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b10001, 5'b11000, 5'b01100,
            5'b10110, 5'b11011, 5'b11101, 5'b01110, 5'b10111, 5'b01011, 5'b10101,
            5'b01010, 5'b00101, 5'b00010};
    total = 0;
    bad   = 0;
    gap   = 0;
    reset       = 1'b1;
    enable      = 1'b1;
    sin_wave    = 12'd3000;
    cos_wave    = 12'd1000;
    sin_wave_f2 = 12'd500;
    fork
      monitor();
    join_none

    // reset state
    repeat (2) @(negedge clk);
    check("rst_lfsr", 12'(lfsr), 12'd1);
    check("rst_tick", 12'(bit_tick), 12'd0);
    check("rst_ask",  ask_mod,  12'd2048);
    check("rst_fsk",  fsk_mod,  12'd2048);
    check("rst_bpsk", bpsk_mod, 12'd2048);
    check("rst_qpsk", sin_qpsk, 12'd2048);
    reset = 1'b0;

    // full 31-state cycle with waveform checks around every tick
    prev_d = 1'b1;
    sym    = 2'b00;
    for (int k = 1; k <= 31; k++) begin
      exp_q.push_back(seq[k % 31]);
      wait_tick("tick", cyc);
      if (k == 1) check("first_tick_cycles", 12'(cyc), 12'd4);
      prev_sym = sym;
      check("tick_cycle_ask_old_d", ask_mod, ask_exp(prev_d));
      check("tick_cycle_qpsk_old_sym", sin_qpsk, qpsk_exp(prev_sym));
      t     = seq[k % 31];
      new_d = t[0];
      if (k % 2 == 0) begin
        t   = seq[(k - 1) % 31];
        sym = t[1:0];
      end
      @(negedge clk);
      check("tick_gap", 12'(gap), 12'd4);
      check_wave("post_tick", new_d, sym);
      prev_d = new_d;
    end

    // one-cycle latency from carrier inputs (d=1, sym=01 here)
    sin_wave = 12'd100;
    cos_wave = 12'd200;
    #1;
    check("latency_ask_hold", ask_mod, 12'd3000);
    @(negedge clk);
    check("latency_ask",  ask_mod,  12'd100);
    check("latency_bpsk", bpsk_mod, 12'd100);
    check("latency_fsk",  fsk_mod,  12'd500);
    check("latency_qpsk", sin_qpsk, 12'd200);
    sin_wave = 12'd3000;
    cos_wave = 12'd1000;
    @(negedge clk);
    check("restore_ask",  ask_mod,  12'd3000);
    check("restore_qpsk", sin_qpsk, 12'd1000);

    // tick 32, then freeze enable mid-bit
    exp_q.push_back(seq[1]);
    wait_tick("tick32", cyc);
    @(negedge clk);
    check("tick32_gap", 12'(gap), 12'd4);
    check_wave("tick32", 1'b0, 2'b01);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("frozen_tick", 12'(bit_tick), 12'd0);
      check("frozen_lfsr", 12'(lfsr), 12'(5'b10000));
    end
    check("frozen_ask", ask_mod, 12'd2048);
    enable = 1'b1;
    exp_q.push_back(seq[2]);
    wait_tick("resume", cyc);
    check("resume_cycles", 12'(cyc), 12'd2);
    @(negedge clk);
    check("resume_gap", 12'(gap), 12'd4);

    // asynchronous reset two cycles into a bit
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_lfsr", 12'(lfsr), 12'd1);
    check("async_tick", 12'(bit_tick), 12'd0);
    check("async_ask",  ask_mod,  12'd2048);
    check("async_fsk",  fsk_mod,  12'd2048);
    check("async_bpsk", bpsk_mod, 12'd2048);
    check("async_qpsk", sin_qpsk, 12'd2048);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(seq[1]);
    wait_tick("post_rst", cyc);
    check("post_rst_cycles", 12'(cyc), 12'd4);
    @(negedge clk);
    check("post_rst_gap", 12'(gap), 12'd4);
    check_wave("post_rst", 1'b0, 2'b00);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("end_tick", 12'(bit_tick), 12'd0);
    check("sb_drained", 12'(exp_q.size()), 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
